// File: rtl/data_cache_controller.sv
// Direct-mapped, write-through, no-write-allocate data cache between the MEM
// stage and a req/ack backing memory, with RV32 load/store sizing, flush and
// saturating load hit/miss counters.
module data_cache_controller #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned NUM_SETS       = 16,
    parameter int unsigned WORDS_PER_LINE = 4
) (
    input  logic                  iClk,
    input  logic                  iRstN,
    input  logic                  iReq,
    input  logic                  iWe,
    input  logic [2:0]            iFunct3,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic [DATA_WIDTH-1:0] iWData,
    input  logic                  iFlush,
    output logic                  oReady,
    output logic [DATA_WIDTH-1:0] oRData,
    output logic                  oMisaligned,
    output logic                  oMemReq,
    output logic                  oMemWe,
    output logic [ADDR_WIDTH-1:0] oMemAddr,
    output logic [DATA_WIDTH-1:0] oMemWData,
    output logic [3:0]            oMemBe,
    input  logic                  iMemAck,
    input  logic [DATA_WIDTH-1:0] iMemRData,
    output logic [31:0]           oHitCount,
    output logic [31:0]           oMissCount
);

    localparam int unsigned WORD_BITS = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W     = (WORD_BITS == 0) ? 1 : WORD_BITS;
    localparam int unsigned IDX_W     = $clog2(NUM_SETS);
    localparam int unsigned TAG_LSB   = 2 + WORD_BITS + IDX_W;
    localparam int unsigned TAG_W     = ADDR_WIDTH - TAG_LSB;

    typedef enum logic [1:0] {S_IDLE, S_REFILL, S_RESP, S_WRITE} state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [NUM_SETS-1:0]     valid_q, valid_d;
    logic                    flush_pend_q, flush_pend_d;
    logic [31:0]             hit_q, hit_d;
    logic [31:0]             miss_q, miss_d;
    logic [TAG_W-1:0]        tag_q [NUM_SETS];
    logic [DATA_WIDTH-1:0]   data_q [NUM_SETS][WORDS_PER_LINE];

    logic [1:0]              offset_c;
    logic [CNT_W-1:0]        word_c;
    logic [IDX_W-1:0]        idx_c;
    logic [TAG_W-1:0]        tag_c;
    logic                    hit_c;
    logic                    misaligned_c;
    logic [DATA_WIDTH-1:0]   line_word_c;
    logic [3:0]              st_be_c;
    logic [DATA_WIDTH-1:0]   st_data_c;
    logic [DATA_WIDTH-1:0]   merged_c;
    logic                    fill_we_c, tag_we_c, merge_we_c, do_flush_c;

    // Sign/zero-extended byte, halfword or word at the given byte offset.
    function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f3,
                                            input logic [1:0] off);
        logic [31:0] sh;
        sh = w >> {off, 3'b000};
        case (f3)
            3'b000:  extract = {{24{sh[7]}}, sh[7:0]};
            3'b100:  extract = {24'd0, sh[7:0]};
            3'b001:  extract = {{16{sh[15]}}, sh[15:0]};
            3'b101:  extract = {16'd0, sh[15:0]};
            default: extract = sh;
        endcase
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        sat_inc = (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Address split, lookup, alignment check and store lane positioning.
    always_comb begin
        offset_c    = iAddress[1:0];
        word_c      = CNT_W'((iAddress >> 2) & ADDR_WIDTH'(WORDS_PER_LINE - 1));
        idx_c       = IDX_W'(iAddress >> (2 + WORD_BITS));
        tag_c       = TAG_W'(iAddress >> TAG_LSB);
        hit_c       = valid_q[idx_c] && (tag_q[idx_c] == tag_c);
        line_word_c = data_q[idx_c][word_c];
        case (iFunct3)
            3'b000, 3'b100: misaligned_c = 1'b0;
            3'b001, 3'b101: misaligned_c = offset_c[0];
            3'b010:         misaligned_c = (offset_c != 2'b00);
            default:        misaligned_c = 1'b1;
        endcase
        case (iFunct3[1:0])
            2'b00: begin
                st_be_c   = 4'b0001 << offset_c;
                st_data_c = {4{iWData[7:0]}};
            end
            2'b01: begin
                st_be_c   = 4'b0011 << offset_c;
                st_data_c = {2{iWData[15:0]}};
            end
            default: begin
                st_be_c   = 4'b1111;
                st_data_c = iWData;
            end
        endcase
        for (int b = 0; b < 4; b++) begin
            merged_c[8*b +: 8] = st_be_c[b] ? st_data_c[8*b +: 8] : line_word_c[8*b +: 8];
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        valid_d      = valid_q;
        flush_pend_d = flush_pend_q;
        hit_d        = hit_q;
        miss_d       = miss_q;
        fill_we_c    = 1'b0;
        tag_we_c     = 1'b0;
        merge_we_c   = 1'b0;
        do_flush_c   = 1'b0;
        oReady       = 1'b0;
        oRData       = '0;
        oMisaligned  = 1'b0;
        oMemReq      = 1'b0;
        oMemWe       = 1'b0;
        oMemAddr     = '0;
        oMemWData    = '0;
        oMemBe       = 4'b0000;
        case (state_q)
            S_IDLE: begin
                if (iReq && iRstN) begin
                    if (misaligned_c) begin
                        oReady      = 1'b1;
                        oMisaligned = 1'b1;
                    end else if (iWe) begin
                        state_d = S_WRITE;
                    end else if (hit_c) begin
                        oReady = 1'b1;
                        oRData = extract(line_word_c, iFunct3, offset_c);
                        hit_d  = sat_inc(hit_q);
                    end else begin
                        state_d = S_REFILL;
                        miss_d  = sat_inc(miss_q);
                        cnt_d   = '0;
                    end
                end
                if (iFlush) begin
                    if (state_d == S_IDLE) do_flush_c = 1'b1;
                    else                   flush_pend_d = 1'b1;
                end
            end
            S_REFILL: begin
                oMemReq  = 1'b1;
                oMemAddr = (ADDR_WIDTH'(tag_c) << TAG_LSB)
                         | (ADDR_WIDTH'(idx_c) << (2 + WORD_BITS))
                         | (ADDR_WIDTH'(cnt_q) << 2);
                if (iFlush) flush_pend_d = 1'b1;
                if (iMemAck) begin
                    fill_we_c = 1'b1;
                    cnt_d     = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WORDS_PER_LINE - 1)) begin
                        tag_we_c       = 1'b1;
                        valid_d[idx_c] = 1'b1;
                        state_d        = S_RESP;
                    end
                end
            end
            S_RESP: begin
                oReady  = 1'b1;
                oRData  = extract(line_word_c, iFunct3, offset_c);
                state_d = S_IDLE;
                if (iFlush || flush_pend_q) do_flush_c = 1'b1;
            end
            S_WRITE: begin
                oMemReq   = 1'b1;
                oMemWe    = 1'b1;
                oMemAddr  = {iAddress[ADDR_WIDTH-1:2], 2'b00};
                oMemWData = st_data_c;
                oMemBe    = st_be_c;
                if (iMemAck) begin
                    oReady     = 1'b1;
                    merge_we_c = hit_c;
                    state_d    = S_IDLE;
                    if (iFlush || flush_pend_q) do_flush_c = 1'b1;
                end else if (iFlush) begin
                    flush_pend_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (do_flush_c) begin
            valid_d      = '0;
            flush_pend_d = 1'b0;
        end
    end

    // Control state, valid bits and counters.
    always_ff @(posedge iClk or negedge iRstN) begin
        if (!iRstN) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            valid_q      <= '0;
            flush_pend_q <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            valid_q      <= valid_d;
            flush_pend_q <= flush_pend_d;
            hit_q        <= hit_d;
            miss_q       <= miss_d;
        end
    end

    // Tag and data storage; qualified by valid bits so no reset is needed.
    always_ff @(posedge iClk) begin
        if (fill_we_c)  data_q[idx_c][cnt_q]  <= iMemRData;
        if (merge_we_c) data_q[idx_c][word_c] <= merged_c;
        if (tag_we_c)   tag_q[idx_c]          <= tag_c;
    end

    assign oHitCount  = hit_q;
    assign oMissCount = miss_q;

endmodule

// File: tb/tb_data_cache_controller.sv
// Self-checking bench for data_cache_controller with a word-addressed backing memory model.
module tb_data_cache_controller;

    logic        iClk, iRstN, iReq, iWe, iFlush, iMemAck;
    logic [2:0]  iFunct3;
    logic [31:0] iAddress, iWData, iMemRData;
    logic        oReady, oMisaligned, oMemReq, oMemWe;
    logic [31:0] oRData, oMemAddr, oMemWData, oHitCount, oMissCount;
    logic [3:0]  oMemBe;

    data_cache_controller dut (
        .iClk(iClk), .iRstN(iRstN), .iReq(iReq), .iWe(iWe), .iFunct3(iFunct3),
        .iAddress(iAddress), .iWData(iWData), .iFlush(iFlush),
        .oReady(oReady), .oRData(oRData), .oMisaligned(oMisaligned),
        .oMemReq(oMemReq), .oMemWe(oMemWe), .oMemAddr(oMemAddr),
        .oMemWData(oMemWData), .oMemBe(oMemBe), .iMemAck(iMemAck),
        .iMemRData(iMemRData), .oHitCount(oHitCount), .oMissCount(oMissCount)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    logic [31:0] mem [1024];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [31:0] rd_log [$];
    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        memreq_seen;

    // Backing memory: acks every request one beat per cycle, writes land on ack.
    always @(negedge iClk) begin
        iMemAck   = oMemReq;
        iMemRData = mem[oMemAddr[11:2]];
        if (oMemReq && oMemWe) begin
            for (int b = 0; b < 4; b++)
                if (oMemBe[b]) mem[oMemAddr[11:2]][8*b +: 8] = oMemWData[8*b +: 8];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One CPU access; returns data, misaligned flag and stall cycles before oReady.
    task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input int flush_at,
                          output logic [31:0] rdata, output logic mis, output int cyc);
        bit done;
        done = 0; cyc = 0; rdata = '0; mis = 1'b0;
        rd_log.delete();
        memreq_seen = 1'b0;
        iReq = 1'b1; iWe = we; iFunct3 = f3; iAddress = addr; iWData = wdata;
        for (int k = 0; k < 40; k++) begin
            @(negedge iClk); #1;
            if (oMemReq) memreq_seen = 1'b1;
            if (oMemReq && iMemAck && !oMemWe) rd_log.push_back(oMemAddr);
            if (oMemReq && oMemWe) begin wr_be = oMemBe; wr_data = oMemWData; end
            iFlush = (k == flush_at);
            if (oReady) begin
                rdata = oRData; mis = oMisaligned; done = 1;
                break;
            end
            cyc++;
        end
        if (!done) begin
            n_cmp++; n_fail++;
            $display("FAIL timeout: no oReady for addr %h", addr);
        end
        @(posedge iClk); #1;
        iReq = 1'b0; iFlush = 1'b0;
    endtask

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    vec_t        vecs [10];
    logic [31:0] rd;
    logic        mis;
    int          cyc;

    initial begin
        vecs[0] = '{1'b0, 3'b000, 32'h10E, 32'h0, 32'hFFFF_FFFF, 1'b0};
        vecs[1] = '{1'b0, 3'b000, 32'h10F, 32'h0, 32'hFFFF_FF80, 1'b0};
        vecs[2] = '{1'b0, 3'b100, 32'h10F, 32'h0, 32'h0000_0080, 1'b0};
        vecs[3] = '{1'b0, 3'b001, 32'h10E, 32'h0, 32'hFFFF_80FF, 1'b0};
        vecs[4] = '{1'b0, 3'b101, 32'h10E, 32'h0, 32'h0000_80FF, 1'b0};
        vecs[5] = '{1'b0, 3'b010, 32'h104, 32'h0, 32'h2222_2222, 1'b0};
        vecs[6] = '{1'b0, 3'b010, 32'h102, 32'h0, 32'h0,         1'b1};
        vecs[7] = '{1'b0, 3'b001, 32'h101, 32'h0, 32'h0,         1'b1};
        vecs[8] = '{1'b0, 3'b011, 32'h100, 32'h0, 32'h0,         1'b1};
        vecs[9] = '{1'b1, 3'b010, 32'h101, 32'h5, 32'h0,         1'b1};

        for (int i = 0; i < 1024; i++) mem[i] = 32'hC0DE_0000 | (i * 4);
        mem[32'h100 >> 2] = 32'h1111_1111;
        mem[32'h104 >> 2] = 32'h2222_2222;
        mem[32'h108 >> 2] = 32'h3333_3333;
        mem[32'h10C >> 2] = 32'h4444_4444;
        mem[32'h400 >> 2] = 32'h0;

        iRstN = 1'b0; iReq = 1'b0; iWe = 1'b0; iFunct3 = 3'b010; iAddress = '0;
        iWData = '0; iFlush = 1'b0;
        repeat (2) @(posedge iClk);
        #1;
        check("rst_ready",   {31'd0, oReady},      32'd0);
        check("rst_mis",     {31'd0, oMisaligned}, 32'd0);
        check("rst_memreq",  {31'd0, oMemReq},     32'd0);
        check("rst_memwe",   {31'd0, oMemWe},      32'd0);
        check("rst_be",      {28'd0, oMemBe},      32'd0);
        check("rst_rdata",   oRData,               32'd0);
        check("rst_memaddr", oMemAddr,             32'd0);
        check("rst_wdata",   oMemWData,            32'd0);
        check("rst_hits",    oHitCount,            32'd0);
        check("rst_misses",  oMissCount,           32'd0);
        iRstN = 1'b1;
        @(posedge iClk); #1;

        // Cold miss with a four-beat ascending refill
        access(1'b0, 3'b010, 32'h100, 32'h0, -1, rd, mis, cyc);
        check("miss_cycles", cyc, 32'd5);
        check("miss_beats", rd_log.size(), 32'd4);
        for (int i = 0; i < 4 && i < rd_log.size(); i++)
            check("refill_addr", rd_log[i], 32'h100 + 32'(i * 4));
        check("miss_rdata", rd, 32'h1111_1111);
        check("miss_count1", oMissCount, 32'd1);
        check("hit_count0", oHitCount, 32'd0);

        // Store hit on word 0x10C
        access(1'b1, 3'b010, 32'h10C, 32'h80FF_0000, -1, rd, mis, cyc);
        check("sw_cycles", cyc, 32'd1);
        check("sw_be", {28'd0, wr_be}, 32'hF);
        check("sw_wdata", wr_data, 32'h80FF_0000);

        // Hits and misaligned rejects
        for (int i = 0; i < 10; i++) begin
            access(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, -1, rd, mis, cyc);
            check($sformatf("vec%0d_cycles", i), cyc, 32'd0);
            check($sformatf("vec%0d_mis", i), {31'd0, mis}, {31'd0, vecs[i].exp_mis});
            if (vecs[i].exp_mis)
                check($sformatf("vec%0d_memreq", i), {31'd0, memreq_seen}, 32'd0);
            else
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
        end
        check("hit_count6", oHitCount, 32'd6);
        check("miss_count_unch", oMissCount, 32'd1);

        // Halfword store hit, merged into the cached word
        access(1'b1, 3'b001, 32'h102, 32'h0000_ABCD, -1, rd, mis, cyc);
        check("sh_be", {28'd0, wr_be}, 32'hC);
        check("sh_wdata", wr_data, 32'hABCD_ABCD);
        check("sh_mem", mem[32'h100 >> 2], 32'hABCD_1111);
        access(1'b0, 3'b010, 32'h100, 32'h0, -1, rd, mis, cyc);
        check("sh_merge_cycles", cyc, 32'd0);
        check("sh_merge_rdata", rd, 32'hABCD_1111);
        check("hit_count7", oHitCount, 32'd7);

        // Store miss does not allocate
        access(1'b1, 3'b010, 32'h400, 32'hDEAD_BEEF, -1, rd, mis, cyc);
        check("swmiss_cycles", cyc, 32'd1);
        access(1'b0, 3'b010, 32'h400, 32'h0, -1, rd, mis, cyc);
        check("noalloc_cycles", cyc, 32'd5);
        check("noalloc_rdata", rd, 32'hDEAD_BEEF);
        check("miss_count2", oMissCount, 32'd2);

        // Flush raised mid-refill: fill completes, then the cache is invalidated
        access(1'b0, 3'b010, 32'h200, 32'h0, 2, rd, mis, cyc);
        check("flushfill_cycles", cyc, 32'd5);
        check("flushfill_rdata", rd, 32'hC0DE_0200);
        access(1'b0, 3'b010, 32'h200, 32'h0, -1, rd, mis, cyc);
        check("postflush_cycles", cyc, 32'd5);
        check("miss_count4", oMissCount, 32'd4);

        // Conflict eviction, then an idle flush
        access(1'b0, 3'b010, 32'h100, 32'h0, -1, rd, mis, cyc);
        check("evict_rdata", rd, 32'hABCD_1111);
        iFlush = 1'b1;
        @(posedge iClk); #1;
        iFlush = 1'b0;
        access(1'b0, 3'b010, 32'h100, 32'h0, -1, rd, mis, cyc);
        check("idleflush_cycles", cyc, 32'd5);
        check("miss_count6", oMissCount, 32'd6);

        // Reset during the third refill beat
        iReq = 1'b1; iWe = 1'b0; iFunct3 = 3'b010; iAddress = 32'h300;
        repeat (4) @(negedge iClk);
        #1;
        check("beat3_addr", oMemAddr, 32'h308);
        iRstN = 1'b0;
        #1;
        check("abort_memreq", {31'd0, oMemReq}, 32'd0);
        check("abort_ready", {31'd0, oReady}, 32'd0);
        check("abort_memaddr", oMemAddr, 32'd0);
        check("abort_misses", oMissCount, 32'd0);
        check("abort_hits", oHitCount, 32'd0);
        iReq = 1'b0;
        @(posedge iClk); #1;
        iRstN = 1'b1;
        @(posedge iClk); #1;
        access(1'b0, 3'b010, 32'h300, 32'h0, -1, rd, mis, cyc);
        check("reaccess_cycles", cyc, 32'd5);
        check("reaccess_rdata", rd, 32'hC0DE_0300);
        check("reaccess_misses", oMissCount, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
